// File: rtl/ctrl_fsm_param.sv
// Instruction sequencer for the down-sampler core: fetches, decodes and drives datapath/RAM controls.
// Every control output is registered and changes on the edge that enters the state owning it.
module ctrl_fsm_param #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned OPC_W   = 6,
    parameter int unsigned REG_W   = 3,
    parameter int unsigned DSEL_W  = 4,
    parameter int unsigned CTRL_W  = 4,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               zero,
    input  logic               great,
    output logic [REG_W-1:0]   flagA,
    output logic [REG_W-1:0]   flagB,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [DSEL_W-1:0]  sel_d,
    output logic [INSTR_W-1:0] constant,
    output logic               incr_en,
    output logic               ir_en,
    output logic               merge_en,
    output logic               sel_c,
    output logic [1:0]         d_RAM_en,
    output logic               mem_write_en,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);
    localparam int unsigned F = INSTR_W - OPC_W - 1;
    localparam logic [3:0] MemWaitInit = 4'(MEM_LAT - 1);

    typedef enum logic [3:0] {
        StIdle, StFetch1, StFetch2, StDecode, StExec, StCFetch, StCCollect,
        StSettle, StMemWait, StBFetch, StBCheck, StHalt
    } state_e;

    typedef enum logic [3:0] {
        ClsAlu, ClsConst, ClsMerge, ClsMemWrite, ClsMemRead, ClsJumpZ,
        ClsJumpNz, ClsOver, ClsJumpG, ClsNop, ClsIllegal
    } cls_e;

    function automatic cls_e classify(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_W'(1), OPC_W'(2), OPC_W'(3), OPC_W'(4), OPC_W'(5),
            OPC_W'(6), OPC_W'(7), OPC_W'(8), OPC_W'(9): return ClsAlu;
            OPC_W'(10): return ClsConst;
            OPC_W'(11): return ClsMerge;
            OPC_W'(12): return ClsMemWrite;
            OPC_W'(13): return ClsMemRead;
            OPC_W'(14): return ClsJumpZ;
            OPC_W'(15): return ClsJumpNz;
            OPC_W'(16): return ClsOver;
            OPC_W'(17): return ClsJumpG;
            OPC_W'(18): return ClsNop;
            default:    return ClsIllegal;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [REG_W-1:0]   flag_a_q, flag_a_d, flag_b_q, flag_b_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [DSEL_W-1:0]  sel_d_q, sel_d_d;
    logic [INSTR_W-1:0] constant_q, constant_d;
    logic [1:0]         d_ram_en_q, d_ram_en_d;
    logic incr_en_q, incr_en_d, ir_en_q, ir_en_d, merge_en_q, merge_en_d;
    logic sel_c_q, sel_c_d, mem_write_en_q, mem_write_en_d;
    logic busy_q, busy_d, halted_q, halted_d, illegal_q, illegal_d;

    logic [OPC_W-1:0] in_opc;
    cls_e             in_cls, hold_cls;
    logic             go_fetch1, go_park, park_halted, taken;

    assign in_opc   = instruction[INSTR_W-1 -: OPC_W];
    assign in_cls   = classify(in_opc);
    assign hold_cls = classify(hold_q[INSTR_W-1 -: OPC_W]);

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        cnt_d          = cnt_q;
        flag_a_d       = flag_a_q;
        flag_b_d       = flag_b_q;
        ctrl_d         = ctrl_q;
        sel_d_d        = sel_d_q;
        constant_d     = constant_q;
        d_ram_en_d     = d_ram_en_q;
        incr_en_d      = incr_en_q;
        ir_en_d        = ir_en_q;
        merge_en_d     = merge_en_q;
        sel_c_d        = sel_c_q;
        mem_write_en_d = mem_write_en_q;
        halted_d       = halted_q;
        illegal_d      = 1'b0;
        go_fetch1      = 1'b0;
        go_park        = 1'b0;
        park_halted    = 1'b0;
        taken          = 1'b0;

        case (state_q)
            StIdle:   go_fetch1 = start;
            StHalt:   go_fetch1 = start;
            StFetch1: begin
                state_d   = StFetch2;
                incr_en_d = 1'b0;
            end
            StFetch2: begin
                // Outputs for DECODE come straight from the IR; the word is kept for later states.
                state_d = StDecode;
                hold_d  = instruction;
                ir_en_d = 1'b0;
                case (in_cls)
                    ClsAlu: begin
                        flag_a_d = instruction[F -: REG_W];
                        flag_b_d = instruction[F-REG_W -: REG_W];
                        sel_c_d  = 1'b1;
                        ctrl_d   = in_opc[CTRL_W-1:0];
                    end
                    ClsConst: begin
                        ir_en_d   = 1'b1;
                        incr_en_d = 1'b1;
                        sel_c_d   = 1'b0;
                    end
                    ClsMerge:    merge_en_d = 1'b1;
                    ClsMemWrite: d_ram_en_d = 2'b11;
                    ClsMemRead: begin
                        d_ram_en_d     = 2'b00;
                        mem_write_en_d = 1'b1;
                    end
                    ClsJumpZ, ClsJumpNz, ClsJumpG: begin
                        flag_a_d  = instruction[F -: REG_W];
                        flag_b_d  = instruction[F-REG_W -: REG_W];
                        ctrl_d    = CTRL_W'(2);
                        ir_en_d   = 1'b1;
                        incr_en_d = 1'b1;
                    end
                    ClsIllegal: illegal_d = 1'b1;
                    default: ;
                endcase
            end
            StDecode: begin
                case (hold_cls)
                    ClsAlu: begin
                        state_d  = StExec;
                        sel_d_d  = hold_q[DSEL_W-1:0];
                        flag_a_d = hold_q[F -: REG_W];
                        flag_b_d = hold_q[F-REG_W -: REG_W];
                    end
                    ClsConst: begin
                        state_d   = StCFetch;
                        incr_en_d = 1'b0;
                    end
                    ClsMemRead: begin
                        state_d = StMemWait;
                        cnt_d   = MemWaitInit;
                    end
                    ClsJumpZ, ClsJumpNz, ClsJumpG: begin
                        state_d   = StBFetch;
                        incr_en_d = 1'b0;
                        ir_en_d   = 1'b1;
                    end
                    ClsOver: begin
                        go_park     = 1'b1;
                        park_halted = 1'b1;
                    end
                    default: go_fetch1 = 1'b1;
                endcase
            end
            StExec:   go_fetch1 = 1'b1;
            StCFetch: begin
                state_d    = StCCollect;
                constant_d = instruction;
                sel_d_d    = hold_q[F -: DSEL_W];
            end
            StCCollect: state_d = StSettle;
            StSettle:   go_fetch1 = 1'b1;
            StMemWait: begin
                if (cnt_q == 4'd0) go_fetch1 = 1'b1;
                else               cnt_d = cnt_q - 4'd1;
            end
            StBFetch: begin
                state_d    = StBCheck;
                ir_en_d    = 1'b0;
                constant_d = instruction;
            end
            StBCheck: begin
                state_d = StSettle;
                case (hold_cls)
                    ClsJumpZ:  taken = zero;
                    ClsJumpNz: taken = !zero;
                    ClsJumpG:  taken = great;
                    default:   taken = 1'b0;
                endcase
                // Not taken leaves sel_d at 0, so the PC stays past the target word.
                if (taken) begin
                    sel_c_d = 1'b0;
                    sel_d_d = DSEL_W'(1);
                end
            end
            default: go_park = 1'b1;
        endcase

        if (go_fetch1) begin
            state_d        = StFetch1;
            ir_en_d        = 1'b1;
            incr_en_d      = 1'b1;
            d_ram_en_d     = 2'b10;
            merge_en_d     = 1'b0;
            mem_write_en_d = 1'b0;
            sel_c_d        = 1'b0;
            sel_d_d        = '0;
            ctrl_d         = '0;
            flag_a_d       = '0;
            flag_b_d       = '0;
            halted_d       = 1'b0;
        end

        if (go_park) begin
            state_d        = park_halted ? StHalt : StIdle;
            ir_en_d        = 1'b0;
            incr_en_d      = 1'b0;
            d_ram_en_d     = 2'b10;
            merge_en_d     = 1'b0;
            mem_write_en_d = 1'b0;
            sel_c_d        = 1'b0;
            sel_d_d        = '0;
            ctrl_d         = '0;
            flag_a_d       = '0;
            flag_b_d       = '0;
            constant_d     = '0;
            halted_d       = park_halted;
        end

        busy_d = (state_d != StIdle) && (state_d != StHalt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            hold_q         <= '0;
            cnt_q          <= '0;
            flag_a_q       <= '0;
            flag_b_q       <= '0;
            ctrl_q         <= '0;
            sel_d_q        <= '0;
            constant_q     <= '0;
            d_ram_en_q     <= 2'b10;
            incr_en_q      <= 1'b0;
            ir_en_q        <= 1'b0;
            merge_en_q     <= 1'b0;
            sel_c_q        <= 1'b0;
            mem_write_en_q <= 1'b0;
            busy_q         <= 1'b0;
            halted_q       <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            cnt_q          <= cnt_d;
            flag_a_q       <= flag_a_d;
            flag_b_q       <= flag_b_d;
            ctrl_q         <= ctrl_d;
            sel_d_q        <= sel_d_d;
            constant_q     <= constant_d;
            d_ram_en_q     <= d_ram_en_d;
            incr_en_q      <= incr_en_d;
            ir_en_q        <= ir_en_d;
            merge_en_q     <= merge_en_d;
            sel_c_q        <= sel_c_d;
            mem_write_en_q <= mem_write_en_d;
            busy_q         <= busy_d;
            halted_q       <= halted_d;
            illegal_q      <= illegal_d;
        end
    end

    assign flagA        = flag_a_q;
    assign flagB        = flag_b_q;
    assign ctrl         = ctrl_q;
    assign sel_d        = sel_d_q;
    assign constant     = constant_q;
    assign incr_en      = incr_en_q;
    assign ir_en        = ir_en_q;
    assign merge_en     = merge_en_q;
    assign sel_c        = sel_c_q;
    assign d_RAM_en     = d_ram_en_q;
    assign mem_write_en = mem_write_en_q;
    assign busy         = busy_q;
    assign halted       = halted_q;
    assign illegal      = illegal_q;

endmodule
